// File: rtl/aig_tt_eval.sv
// Streaming 4-input AIG evaluator: takes one AND node per beat, builds each
// node's 16-bit truth table and returns the output literal's truth table.
`timescale 1ns/1ps
module aig_tt_eval #(
  parameter int unsigned MAX_NODES = 16,
  parameter int unsigned IDX_W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_a_idx,
  input  logic             in_a_inv,
  input  logic [IDX_W-1:0] in_b_idx,
  input  logic             in_b_inv,
  input  logic             in_last,
  input  logic [IDX_W-1:0] in_out_idx,
  input  logic             in_out_inv,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_tt,
  output logic [IDX_W-1:0] out_nodes,
  output logic             out_err
);

  typedef enum logic {S_LOAD, S_RESULT} state_e;

  state_e           state_q;
  logic [IDX_W-1:0] k_q;
  logic             err_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [15:0]      out_tt_q;
  logic [IDX_W-1:0] out_nodes_q;
  logic             out_err_q;
  logic [15:0]      mem_q [MAX_NODES];

  logic [IDX_W:0]   lim;
  logic [15:0]      a_raw, b_raw, o_raw, node_tt, res_tt;
  logic             a_ok, b_ok, o_ok, o_self, full;
  logic             beat_err, fin_err, accept, mem_we;

  // Constant 0 and primary inputs; node indices resolve from storage below.
  function automatic logic [15:0] input_tt(input logic [IDX_W-1:0] idx);
    logic [15:0] r;
    r = '0;
    if (idx == IDX_W'(1)) r = 16'hAAAA;
    if (idx == IDX_W'(2)) r = 16'hCCCC;
    if (idx == IDX_W'(3)) r = 16'hF0F0;
    if (idx == IDX_W'(4)) r = 16'hFF00;
    return r;
  endfunction

  always_comb begin
    lim   = {1'b0, k_q} + (IDX_W+1)'(5);
    a_raw = input_tt(in_a_idx);
    b_raw = input_tt(in_b_idx);
    o_raw = input_tt(in_out_idx);
    for (int unsigned j = 0; j < MAX_NODES; j++) begin
      if (in_a_idx   == IDX_W'(j + 5)) a_raw = mem_q[j];
      if (in_b_idx   == IDX_W'(j + 5)) b_raw = mem_q[j];
      if (in_out_idx == IDX_W'(j + 5)) o_raw = mem_q[j];
    end
    a_ok    = {1'b0, in_a_idx} < lim;
    b_ok    = {1'b0, in_b_idx} < lim;
    node_tt = (a_ok && b_ok) ? ((a_raw ^ {16{in_a_inv}}) & (b_raw ^ {16{in_b_inv}})) : '0;
    full    = (k_q == IDX_W'(MAX_NODES));
    // The output may name the node being accepted this cycle, which is not in storage yet.
    o_self   = ({1'b0, in_out_idx} == lim);
    o_ok     = ({1'b0, in_out_idx} <= lim);
    res_tt   = (o_self ? node_tt : o_raw) ^ {16{in_out_inv}};
    beat_err = full | ~a_ok | ~b_ok;
    fin_err  = err_q | beat_err | ~o_ok;
    accept   = in_valid & in_ready_q;
    mem_we   = accept & ~full;
  end

  always_ff @(posedge clk) begin
    for (int unsigned j = 0; j < MAX_NODES; j++) begin
      if (mem_we && k_q == IDX_W'(j)) mem_q[j] <= node_tt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_LOAD;
      k_q         <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_tt_q    <= '0;
      out_nodes_q <= '0;
      out_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (accept) begin
            if (!full) k_q <= k_q + 1'b1;
            err_q <= err_q | beat_err;
            if (in_last) begin
              state_q     <= S_RESULT;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_err_q   <= fin_err;
              out_tt_q    <= fin_err ? '0 : res_tt;
              out_nodes_q <= full ? k_q : k_q + 1'b1;
            end
          end
        end
        S_RESULT: begin
          if (out_ready) begin
            state_q     <= S_LOAD;
            k_q         <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_tt    = out_tt_q;
  assign out_nodes = out_nodes_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_aig_tt_eval.sv
// Directed bench for aig_tt_eval with hand-computed truth tables.
`timescale 1ns/1ps
module tb_aig_tt_eval;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_a_idx;
  logic        in_a_inv;
  logic [4:0]  in_b_idx;
  logic        in_b_inv;
  logic        in_last;
  logic [4:0]  in_out_idx;
  logic        in_out_inv;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_tt;
  logic [4:0]  out_nodes;
  logic        out_err;

  int checks = 0;
  int passes = 0;

  aig_tt_eval #(.MAX_NODES(16), .IDX_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a_idx(in_a_idx), .in_a_inv(in_a_inv),
    .in_b_idx(in_b_idx), .in_b_inv(in_b_inv),
    .in_last(in_last), .in_out_idx(in_out_idx), .in_out_inv(in_out_inv),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_tt(out_tt), .out_nodes(out_nodes), .out_err(out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [4:0] a, input logic ai, input logic [4:0] b, input logic bi,
                      input logic last, input logic [4:0] o, input logic oi);
    in_valid = 1'b1; in_a_idx = a; in_a_inv = ai; in_b_idx = b; in_b_inv = bi;
    in_last = last; in_out_idx = o; in_out_inv = oi;
    chk("in_ready_before_beat", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic take_result(input string tag, input logic [15:0] tt, input logic [4:0] nodes,
                             input logic err);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_tt"},    {16'd0, out_tt},    {16'd0, tt});
    chk({tag, "_nodes"}, {27'd0, out_nodes}, {27'd0, nodes});
    chk({tag, "_err"},   {31'd0, out_err},   {31'd0, err});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_ready_back"}, {31'd0, in_ready},  32'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a_idx = '0; in_a_inv = 1'b0; in_b_idx = '0;
    in_b_inv = 1'b0; in_last = 1'b0; in_out_idx = '0; in_out_inv = 1'b0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_tt",    {16'd0, out_tt},    32'd0);
    chk("rst_out_nodes", {27'd0, out_nodes}, 32'd0);
    chk("rst_out_err",   {31'd0, out_err},   32'd0);
    rst_n = 1'b1;
    tick();

    // 9-node netlist from the reference example
    beat(5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0);
    beat(5'd3, 1'b1, 5'd4, 1'b1, 1'b0, 5'd0, 1'b0);
    beat(5'd5, 1'b0, 5'd6, 1'b1, 1'b0, 5'd0, 1'b0);
    beat(5'd3, 1'b0, 5'd4, 1'b0, 1'b0, 5'd0, 1'b0);
    beat(5'd2, 1'b0, 5'd6, 1'b1, 1'b0, 5'd0, 1'b0);
    beat(5'd1, 1'b0, 5'd9, 1'b0, 1'b0, 5'd0, 1'b0);
    beat(5'd5, 1'b1, 5'd10, 1'b1, 1'b0, 5'd0, 1'b0);
    chk("net9_no_early_valid", {31'd0, out_valid}, 32'd0);
    beat(5'd8, 1'b1, 5'd11, 1'b0, 1'b0, 5'd0, 1'b0);
    beat(5'd7, 1'b1, 5'd12, 1'b1, 1'b1, 5'd13, 1'b1);
    take_result("net9", 16'h177E, 5'd9, 1'b0);

    beat(5'd1, 1'b0, 5'd2, 1'b0, 1'b1, 5'd5, 1'b0);
    take_result("and12", 16'h8888, 5'd1, 1'b0);
    beat(5'd1, 1'b0, 5'd2, 1'b0, 1'b1, 5'd0, 1'b1);
    take_result("not_const0", 16'hFFFF, 5'd1, 1'b0);
    beat(5'd1, 1'b0, 5'd2, 1'b0, 1'b1, 5'd4, 1'b0);
    take_result("out_x3", 16'hFF00, 5'd1, 1'b0);

    beat(5'd1, 1'b0, 5'd6, 1'b0, 1'b1, 5'd5, 1'b0);
    take_result("fwd_ref", 16'h0000, 5'd1, 1'b1);
    // error flag must have been cleared by the previous handshake
    beat(5'd1, 1'b0, 5'd2, 1'b0, 1'b1, 5'd6, 1'b0);
    take_result("fwd_out", 16'h0000, 5'd1, 1'b1);

    for (int i = 0; i < 16; i++) beat(5'd1, 1'b0, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0);
    beat(5'd1, 1'b0, 5'd2, 1'b0, 1'b1, 5'd5, 1'b0);
    take_result("overflow", 16'h0000, 5'd16, 1'b1);

    // hold result with out_ready low while junk beats are offered
    beat(5'd1, 1'b0, 5'd2, 1'b0, 1'b1, 5'd5, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_a_idx = 5'd3; in_b_idx = 5'd4; in_last = 1'b1; in_out_idx = 5'd5;
      chk("hold_valid",    {31'd0, out_valid}, 32'd1);
      chk("hold_tt",       {16'd0, out_tt},    32'h8888);
      chk("hold_nodes",    {27'd0, out_nodes}, 32'd1);
      chk("hold_in_ready", {31'd0, in_ready},  32'd0);
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
    take_result("hold", 16'h8888, 5'd1, 1'b0);
    beat(5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0);
    beat(5'd5, 1'b0, 5'd3, 1'b1, 1'b1, 5'd6, 1'b0);
    take_result("b2b", 16'h0101, 5'd2, 1'b0);

    beat(5'd1, 1'b0, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0);
    beat(5'd3, 1'b0, 5'd4, 1'b0, 1'b0, 5'd0, 1'b0);
    beat(5'd9, 1'b0, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_ready", {31'd0, in_ready},  32'd1);
    beat(5'd1, 1'b0, 5'd2, 1'b0, 1'b1, 5'd5, 1'b1);
    take_result("after_rst", 16'h7777, 5'd1, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
